// File: rtl/trace_breakpoint_pkg.sv
// Shared types and default sizing for the statement-trace / breakpoint unit.
package trace_breakpoint_pkg;

   localparam int NUM_CH_DEF   = 4;
   localparam int ID_WIDTH_DEF = 32;
   localparam int DEPTH_DEF    = 16;
   localparam int NUM_BP_DEF   = 4;

   // Breakpoint IDs are stored zero-extended to this width, so any ID_WIDTH up to it fits.
   localparam int BP_ID_W = 64;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_STEP = 2'd2
   } run_state_e;

   typedef struct packed {
      logic               arm;
      logic [BP_ID_W-1:0] id;
   } bp_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Multi-write (up to NUM_CH per cycle), single-read show-ahead FIFO.
// Valid write lanes are packed in ascending lane order; lanes that do not fit are refused.
module trace_fifo #(
   parameter  int NUM_CH   = 4,
   parameter  int ID_WIDTH = 32,
   parameter  int DEPTH    = 16,
   localparam int AW       = $clog2(DEPTH),
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          wr_valid,
   input  logic [NUM_CH*ID_WIDTH-1:0] wr_data,
   output logic [NUM_CH-1:0]          accept,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [ID_WIDTH-1:0]        rd_data,
   output logic [CW-1:0]              count,
   output logic [CW-1:0]              free
);

   logic [ID_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       count_q;
   logic [CW-1:0]       push_cnt;
   logic [CW-1:0]       space;
   logic [AW-1:0]       wr_off [NUM_CH];
   logic                pop;

   // NOTE: every variable gets a default before any branch, so no path holds a value (no latch).
   always_comb begin
      pop      = rd_ready && (count_q != '0);
      space    = CW'(DEPTH) - count_q + CW'(pop);
      push_cnt = '0;
      accept   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         wr_off[c] = '0;
         if (wr_valid[c] && (push_cnt < space)) begin
            accept[c] = 1'b1;
            wr_off[c] = AW'(push_cnt);
            push_cnt  = push_cnt + CW'(1);
         end
      end
   end

   // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         wr_ptr  <= wr_ptr + AW'(push_cnt);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count_q <= count_q + push_cnt - CW'(pop);
      end
   end

   // NOTE: storage is not reset; occupancy lives in count_q and the read data is masked when empty.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (accept[c]) mem[wr_ptr + wr_off[c]] <= wr_data[c*ID_WIDTH +: ID_WIDTH];
      end
   end

   assign rd_valid = (count_q != '0);
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
   assign count    = count_q;
   assign free     = space;

endmodule

// File: rtl/trace_breakpoint_unit.sv
// Statement-trace and breakpoint unit: traces hit IDs, halts on armed matches,
// and supports resume / single-step from the debugger host.
module trace_breakpoint_unit
   import trace_breakpoint_pkg::*;
#(
   parameter  int NUM_CH   = NUM_CH_DEF,
   parameter  int ID_WIDTH = ID_WIDTH_DEF,
   parameter  int DEPTH    = DEPTH_DEF,
   parameter  int NUM_BP   = NUM_BP_DEF,
   localparam int IDX_W    = $clog2(NUM_BP),
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          hit_valid,
   input  logic [NUM_CH*ID_WIDTH-1:0] hit_id,
   input  logic                       bp_wr_en,
   input  logic [IDX_W-1:0]           bp_wr_idx,
   input  logic [ID_WIDTH-1:0]        bp_wr_id,
   input  logic                       bp_wr_arm,
   input  logic                       resume,
   input  logic                       step,
   output logic                       halt,
   output logic [ID_WIDTH-1:0]        halt_id,
   output logic                       trace_rd_valid,
   input  logic                       trace_rd_ready,
   output logic [ID_WIDTH-1:0]        trace_rd_data,
   output logic [CW-1:0]              trace_count,
   output logic                       overflow,
   input  logic                       clear_overflow
);

   run_state_e          state_q, state_d;
   bp_entry_t           bp_tbl [NUM_BP];
   logic [NUM_CH-1:0]   hit_match;
   logic                match_any;
   logic [ID_WIDTH-1:0] match_id;
   logic [ID_WIDTH-1:0] halt_id_q, halt_id_d;
   logic                halt_q;
   logic                trace_en;
   logic                overflow_q;
   logic [NUM_CH-1:0]   fifo_wr;
   logic [NUM_CH-1:0]   fifo_accept;
   logic [CW-1:0]       fifo_free;
   logic                overflow_set;

   // Compare against the table as it stood before this cycle's write.
   always_comb begin
      hit_match = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int b = 0; b < NUM_BP; b++) begin
            if (hit_valid[c] && bp_tbl[b].arm &&
                (bp_tbl[b].id == BP_ID_W'(hit_id[c*ID_WIDTH +: ID_WIDTH])))
               hit_match[c] = 1'b1;
         end
      end
   end

   // Descending scan so the lowest matching channel is the one left standing.
   always_comb begin
      match_id = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (hit_match[c]) match_id = hit_id[c*ID_WIDTH +: ID_WIDTH];
      end
   end

   assign match_any = |hit_match;

   always_comb begin
      state_d   = state_q;
      halt_id_d = halt_id_q;
      trace_en  = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            trace_en = 1'b1;
            if (match_any) begin
               state_d   = ST_HALT;
               halt_id_d = match_id;
            end
         end
         ST_HALT: begin
            if (resume)    state_d = ST_RUN;
            else if (step) state_d = ST_STEP;
         end
         ST_STEP: begin
            trace_en = 1'b1;
            state_d  = ST_HALT;
            if (match_any) halt_id_d = match_id;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         halt_q     <= 1'b0;
         halt_id_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         halt_q     <= (state_d == ST_HALT);
         halt_id_q  <= halt_id_d;
         overflow_q <= (overflow_q && !clear_overflow) || overflow_set;
      end
   end

   // The table is cleared on reset so a stale breakpoint can never survive it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NUM_BP; b++) bp_tbl[b] <= '0;
      end else if (bp_wr_en) begin
         bp_tbl[bp_wr_idx] <= '{arm: bp_wr_arm, id: BP_ID_W'(bp_wr_id)};
      end
   end

   assign fifo_wr      = hit_valid & {NUM_CH{trace_en}};
   assign overflow_set = |(fifo_wr & ~fifo_accept);

   trace_fifo #(
      .NUM_CH  (NUM_CH),
      .ID_WIDTH(ID_WIDTH),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_valid(fifo_wr),
      .wr_data (hit_id),
      .accept  (fifo_accept),
      .rd_ready(trace_rd_ready),
      .rd_valid(trace_rd_valid),
      .rd_data (trace_rd_data),
      .count   (trace_count),
      .free    (fifo_free)
   );

   // A refused lane must coincide exactly with a burst larger than the free space.
   assert property (@(posedge clk) disable iff (rst)
      overflow_set == ($countones(fifo_wr) > int'(fifo_free)));

   assign halt     = halt_q;
   assign halt_id  = halt_id_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_trace_breakpoint_unit.sv
// Directed bench for trace_breakpoint_unit: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations at the interesting points.
module tb_trace_breakpoint_unit;

   localparam int NCH = 4;
   localparam int IDW = 32;
   localparam int DEP = 16;
   localparam int NBP = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NCH-1:0]     hit_valid = '0;
   logic [NCH*IDW-1:0] hit_id = '0;
   logic               bp_wr_en = 1'b0;
   logic [1:0]         bp_wr_idx = '0;
   logic [IDW-1:0]     bp_wr_id = '0;
   logic               bp_wr_arm = 1'b0;
   logic               resume = 1'b0;
   logic               step = 1'b0;
   logic               halt;
   logic [IDW-1:0]     halt_id;
   logic               trace_rd_valid;
   logic               trace_rd_ready = 1'b0;
   logic [IDW-1:0]     trace_rd_data;
   logic [4:0]         trace_count;
   logic               overflow;
   logic               clear_overflow = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   trace_breakpoint_unit #(
      .NUM_CH(NCH), .ID_WIDTH(IDW), .DEPTH(DEP), .NUM_BP(NBP)
   ) dut (
      .clk(clk), .rst(rst),
      .hit_valid(hit_valid), .hit_id(hit_id),
      .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx), .bp_wr_id(bp_wr_id), .bp_wr_arm(bp_wr_arm),
      .resume(resume), .step(step), .halt(halt), .halt_id(halt_id),
      .trace_rd_valid(trace_rd_valid), .trace_rd_ready(trace_rd_ready),
      .trace_rd_data(trace_rd_data), .trace_count(trace_count),
      .overflow(overflow), .clear_overflow(clear_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [IDW-1:0] m_q[$];
   bit             m_halt = 1'b0;     // observable halt
   bit             m_stepping = 1'b0; // the single traced cycle of a step
   logic [IDW-1:0] m_halt_id = '0;
   bit             m_ovf = 1'b0;
   bit             m_bp_arm [NBP];
   logic [IDW-1:0] m_bp_id [NBP];
   bit             m_found;
   logic [IDW-1:0] m_first;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_halt = 1'b0; m_stepping = 1'b0; m_halt_id = '0; m_ovf = 1'b0;
         for (int b = 0; b < NBP; b++) begin m_bp_arm[b] = 1'b0; m_bp_id[b] = '0; end
      end else begin
         m_found = 1'b0;
         m_first = '0;
         for (int c = 0; c < NCH; c++)
            if (hit_valid[c] && !m_found)
               for (int b = 0; b < NBP; b++)
                  if (m_bp_arm[b] && m_bp_id[b] == hit_id[c*IDW +: IDW]) begin
                     m_found = 1'b1;
                     m_first = hit_id[c*IDW +: IDW];
                  end
         if (trace_rd_ready && m_q.size() != 0) void'(m_q.pop_front());
         if (clear_overflow) m_ovf = 1'b0;
         if (!m_halt)
            for (int c = 0; c < NCH; c++)
               if (hit_valid[c]) begin
                  if (m_q.size() < DEP) m_q.push_back(hit_id[c*IDW +: IDW]);
                  else m_ovf = 1'b1;
               end
         if (m_stepping) begin
            m_stepping = 1'b0;
            m_halt = 1'b1;
            if (m_found) m_halt_id = m_first;
         end else if (m_halt) begin
            if (resume) m_halt = 1'b0;
            else if (step) begin m_halt = 1'b0; m_stepping = 1'b1; end
         end else if (m_found) begin
            m_halt = 1'b1;
            m_halt_id = m_first;
         end
         if (bp_wr_en) begin
            m_bp_arm[bp_wr_idx] = bp_wr_arm;
            m_bp_id[bp_wr_idx]  = bp_wr_id;
         end
      end
   end

   always @(negedge clk) begin
      check("halt", halt, m_halt);
      check("halt_id", halt_id, m_halt_id);
      check("rd_valid", trace_rd_valid, m_q.size() != 0);
      check("count", trace_count, m_q.size());
      check("rd_data", trace_rd_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
      check("overflow", overflow, m_ovf);
   end

   // ---------------- stimulus ----------------
   task automatic next_cycle();
      @(negedge clk);
      #2;
   endtask

   task automatic set_hit(input int c, input logic [IDW-1:0] id);
      hit_valid[c] = 1'b1;
      hit_id[c*IDW +: IDW] = id;
   endtask

   task automatic clear_hits();
      hit_valid = '0;
      hit_id = '0;
   endtask

   task automatic bp_write(input logic [1:0] idx, input logic [IDW-1:0] id, input logic arm);
      bp_wr_en = 1'b1; bp_wr_idx = idx; bp_wr_id = id; bp_wr_arm = arm;
   endtask

   task automatic burst4(input logic [IDW-1:0] base);
      for (int c = 0; c < NCH; c++) set_hit(c, base + IDW'(c));
   endtask

   initial begin
      next_cycle();
      check("rst_halt", halt, 1'b0);
      check("rst_halt_id", halt_id, 32'h0);
      check("rst_count", trace_count, 5'd0);
      check("rst_data", trace_rd_data, 32'h0);
      check("rst_ovf", overflow, 1'b0);
      next_cycle();
      rst = 1'b0;

      // Breakpoint on 0x3; hits ch0=0x2, ch2=0x3 halt and are both traced in order.
      next_cycle();
      bp_write(2'd0, 32'h3, 1'b1);
      next_cycle();
      bp_wr_en = 1'b0;
      set_hit(0, 32'h2); set_hit(2, 32'h3);
      next_cycle();
      clear_hits();
      check("t1_halt", halt, 1'b1);
      check("t1_halt_id", halt_id, 32'h3);
      check("t1_count", trace_count, 5'd2);
      check("t1_head", trace_rd_data, 32'h2);
      trace_rd_ready = 1'b1;
      next_cycle();
      trace_rd_ready = 1'b0;
      check("t1_second", trace_rd_data, 32'h3);

      // Hits while halted are ignored; resume drops halt next cycle.
      for (int i = 0; i < 3; i++) begin
         set_hit(0, 32'h3); set_hit(2, 32'h11);
         next_cycle();
      end
      clear_hits();
      check("t2_count", trace_count, 5'd1);
      resume = 1'b1;
      next_cycle();
      resume = 1'b0;
      check("t2_resumed", halt, 1'b0);
      set_hit(1, 32'h3);
      next_cycle();
      clear_hits();
      check("t2_rehalt", halt, 1'b1);

      // Single step with ch1=0x7 held.
      step = 1'b1;
      set_hit(1, 32'h7);
      next_cycle();
      step = 1'b0;
      check("t3_step_low", halt, 1'b0);
      check("t3_not_yet", trace_count, 5'd2);
      next_cycle();
      clear_hits();
      check("t3_step_high", halt, 1'b1);
      check("t3_count", trace_count, 5'd3);

      // Fill to 14, then overflow with and without a simultaneous pop.
      resume = 1'b1;
      next_cycle();
      resume = 1'b0;
      burst4(32'h10); next_cycle();
      burst4(32'h14); next_cycle();
      clear_hits();
      set_hit(0, 32'h18); set_hit(1, 32'h19); set_hit(2, 32'h1A);
      next_cycle();
      clear_hits();
      check("t4_fill", trace_count, 5'd14);
      burst4(32'h20);
      next_cycle();
      clear_hits();
      check("t4_full", trace_count, 5'd16);
      check("t4_ovf", overflow, 1'b1);
      clear_overflow = 1'b1;
      set_hit(0, 32'h30);
      next_cycle();
      clear_hits();
      check("t4_clr_vs_set", overflow, 1'b1);
      trace_rd_ready = 1'b1;
      next_cycle();
      clear_overflow = 1'b0;
      next_cycle();
      check("t4_cleared", overflow, 1'b0);
      check("t4_refill", trace_count, 5'd14);
      burst4(32'h40);
      next_cycle();
      clear_hits();
      check("t4_pop_full", trace_count, 5'd16);
      check("t4_pop_ovf", overflow, 1'b1);
      repeat (13) next_cycle();
      check("t4_tail_head", trace_rd_data, 32'h40);
      check("t4_tail_count", trace_count, 5'd3);
      repeat (3) next_cycle();
      trace_rd_ready = 1'b0;
      check("t4_empty", trace_rd_valid, 1'b0);

      // Write-cycle compare uses the old table; disarm takes effect too.
      bp_write(2'd1, 32'h9, 1'b1);
      set_hit(3, 32'h9);
      next_cycle();
      bp_wr_en = 1'b0;
      clear_hits();
      check("t5_same_cycle", halt, 1'b0);
      set_hit(3, 32'h9);
      next_cycle();
      clear_hits();
      check("t5_next_cycle", halt, 1'b1);
      check("t5_halt_id", halt_id, 32'h9);
      resume = 1'b1;
      next_cycle();
      resume = 1'b0;
      bp_write(2'd1, 32'h9, 1'b0);
      next_cycle();
      bp_wr_en = 1'b0;
      set_hit(2, 32'h9);
      next_cycle();
      clear_hits();
      check("t5_disarmed", halt, 1'b0);
      set_hit(0, 32'h0);
      next_cycle();
      clear_hits();
      check("t5_zero_id", halt, 1'b0);
      bp_write(2'd2, 32'h5, 1'b1);
      next_cycle();
      bp_wr_en = 1'b0;
      set_hit(1, 32'h5); set_hit(3, 32'h3);
      next_cycle();
      clear_hits();
      check("t5_lowest_ch", halt_id, 32'h5);
      resume = 1'b1;
      next_cycle();
      resume = 1'b0;
      trace_rd_ready = 1'b1;
      repeat (8) next_cycle();
      trace_rd_ready = 1'b0;
      check("t5_drained", trace_count, 5'd0);

      // Reset while halted with 10 entries and overflow still set.
      bp_write(2'd1, 32'h9, 1'b1);
      next_cycle();
      bp_wr_en = 1'b0;
      burst4(32'h50); next_cycle();
      burst4(32'h54); next_cycle();
      clear_hits();
      set_hit(0, 32'h60); set_hit(1, 32'h3);
      next_cycle();
      clear_hits();
      check("t6_halt", halt, 1'b1);
      check("t6_count", trace_count, 5'd10);
      check("t6_ovf_before", overflow, 1'b1);
      rst = 1'b1;
      #1;
      check("t6_rst_halt", halt, 1'b0);
      check("t6_rst_count", trace_count, 5'd0);
      check("t6_rst_ovf", overflow, 1'b0);
      check("t6_rst_valid", trace_rd_valid, 1'b0);
      next_cycle();
      rst = 1'b0;
      set_hit(0, 32'h9);
      next_cycle();
      clear_hits();
      check("t6_bp1_gone", halt, 1'b0);
      check("t6_traced", trace_rd_data, 32'h9);
      set_hit(0, 32'h3);
      next_cycle();
      clear_hits();
      check("t6_bp0_gone", halt, 1'b0);
      check("t6_count2", trace_count, 5'd2);
      next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
